// File: rtl/display_selector_pipe.sv
// Display selector: forwards the processing address while Sobel runs, then reads out
// one of six display modes to the VGA driver, aligning colour and valid with the memory latency.
module display_selector_pipe #(
    parameter int ADDR_W = 10,
    parameter int CH_W   = 4,
    parameter int RD_LAT = 1,
    parameter int THRESH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          sel,
    input  logic                proc_done,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [ADDR_W-1:0]   vga_addr,
    input  logic                vga_valid,
    input  logic                frame_start,
    input  logic [3*CH_W-1:0]   rgb_in,
    input  logic [3*CH_W-1:0]   gray_in,
    input  logic [3*CH_W-1:0]   gx_in,
    input  logic [3*CH_W-1:0]   gy_in,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                pix_valid,
    output logic [2:0]          active_sel,
    output logic                disp_active
);

    typedef enum logic [1:0] {
        PROC,
        WAIT_FRAME,
        DISPLAY
    } state_t;

    state_t state, state_next;

    logic              frame_take;
    logic              issue_valid;
    logic [2:0]        issue_mode;
    logic [RD_LAT:0]   valid_pipe;
    logic [2:0]        mode_pipe [RD_LAT+1];
    logic              d_valid;
    logic [2:0]        d_mode;
    logic [CH_W-1:0]   gx_lo, gy_lo;
    logic [CH_W:0]     mag_sum;
    logic [CH_W-1:0]   mag;
    logic              edge_hit;
    logic [CH_W-1:0]   col_r, col_g, col_b;
    logic              unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PROC;
        end else begin
            state <= state_next;
        end
    end

    // Dropping proc_done returns to PROC from any state, overriding frame_start.
    always_comb begin
        state_next = state;
        case (state)
            PROC:       if (proc_done) state_next = WAIT_FRAME;
            WAIT_FRAME: if (frame_start) state_next = DISPLAY;
            DISPLAY:    state_next = DISPLAY;
            default:    state_next = PROC;
        endcase
        if (!proc_done) begin
            state_next = PROC;
        end
    end

    assign frame_take  = proc_done && frame_start && (state == WAIT_FRAME || state == DISPLAY);
    assign issue_mode  = frame_take ? sel : active_sel;
    assign issue_valid = proc_done && vga_valid &&
                         ((state == DISPLAY) || (state == WAIT_FRAME && frame_start));
    assign disp_active = (state == DISPLAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr    <= '0;
            active_sel <= '0;
        end else begin
            rd_addr <= (state == PROC) ? proc_addr : vga_addr;
            if (frame_take) begin
                active_sel <= sel;
            end
        end
    end

    // Stage 0 travels with rd_addr; the remaining RD_LAT stages cover the memory read.
    always_ff @(posedge clk) begin
        if (rst || !proc_done) begin
            valid_pipe <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                mode_pipe[i] <= '0;
            end
        end else begin
            valid_pipe <= {valid_pipe[RD_LAT-1:0], issue_valid};
            mode_pipe[0] <= issue_mode;
            for (int i = 1; i <= RD_LAT; i++) begin
                mode_pipe[i] <= mode_pipe[i-1];
            end
        end
    end

    assign d_valid  = valid_pipe[RD_LAT];
    assign d_mode   = mode_pipe[RD_LAT];
    assign gx_lo    = gx_in[CH_W-1:0];
    assign gy_lo    = gy_in[CH_W-1:0];
    assign mag_sum  = {1'b0, gx_lo} + {1'b0, gy_lo};
    assign mag      = mag_sum[CH_W] ? {CH_W{1'b1}} : mag_sum[CH_W-1:0];
    assign edge_hit = (int'(mag) >= THRESH);

    assign unused_bits = ^{gx_in[3*CH_W-1:CH_W], gy_in[3*CH_W-1:CH_W]};

    always_comb begin
        col_r = '0;
        col_g = '0;
        col_b = '0;
        case (d_mode)
            3'd0: begin
                col_r = rgb_in[3*CH_W-1:2*CH_W];
                col_g = rgb_in[2*CH_W-1:CH_W];
                col_b = rgb_in[CH_W-1:0];
            end
            3'd1: begin
                col_r = gray_in[3*CH_W-1:2*CH_W];
                col_g = gray_in[2*CH_W-1:CH_W];
                col_b = gray_in[CH_W-1:0];
            end
            3'd2: begin
                col_r = gx_lo;
                col_g = gx_lo;
                col_b = gx_lo;
            end
            3'd3: begin
                col_r = gy_lo;
                col_g = gy_lo;
                col_b = gy_lo;
            end
            3'd4: begin
                col_r = mag;
                col_g = mag;
                col_b = mag;
            end
            3'd5: begin
                col_r = {CH_W{edge_hit}};
                col_g = {CH_W{edge_hit}};
                col_b = {CH_W{edge_hit}};
            end
            default: begin
                col_r = '0;
                col_g = '0;
                col_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !proc_done) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            pix_valid <= 1'b0;
        end else begin
            red       <= d_valid ? col_r : '0;
            green     <= d_valid ? col_g : '0;
            blue      <= d_valid ? col_b : '0;
            pix_valid <= d_valid;
        end
    end

endmodule

// File: tb/tb_display_selector_pipe.sv
// Directed bench for display_selector_pipe with behavioural one-cycle-latency image memories.
module tb_display_selector_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel;
    logic        proc_done;
    logic [9:0]  proc_addr;
    logic [9:0]  vga_addr;
    logic        vga_valid;
    logic        frame_start;
    logic [11:0] rgb_in, gray_in, gx_in, gy_in;
    logic [9:0]  rd_addr;
    logic [3:0]  red, green, blue;
    logic        pix_valid;
    logic [2:0]  active_sel;
    logic        disp_active;

    logic [11:0] rgb_mem  [1024];
    logic [11:0] gray_mem [1024];
    logic [11:0] gx_mem   [1024];
    logic [11:0] gy_mem   [1024];

    int vectors = 0;
    int miscompares = 0;

    display_selector_pipe #(.ADDR_W(10), .CH_W(4), .RD_LAT(1), .THRESH(8)) dut (
        .clk(clk), .rst(rst), .sel(sel), .proc_done(proc_done),
        .proc_addr(proc_addr), .vga_addr(vga_addr), .vga_valid(vga_valid),
        .frame_start(frame_start), .rgb_in(rgb_in), .gray_in(gray_in),
        .gx_in(gx_in), .gy_in(gy_in), .rd_addr(rd_addr), .red(red),
        .green(green), .blue(blue), .pix_valid(pix_valid),
        .active_sel(active_sel), .disp_active(disp_active)
    );

    always #5 clk = ~clk;

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        rgb_in  <= rgb_mem[rd_addr];
        gray_in <= gray_mem[rd_addr];
        gx_in   <= gx_mem[rd_addr];
        gy_in   <= gy_mem[rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkPixel(input string tag, input logic [11:0] exp_rgb, input logic exp_valid);
        checkOutput({tag, ".rgb"}, {20'd0, red, green, blue}, {20'd0, exp_rgb});
        checkOutput({tag, ".valid"}, {31'd0, pix_valid}, {31'd0, exp_valid});
    endtask

    // Issue one visible pixel, then wait until its colour is registered.
    task automatic applyStimulus(input logic [2:0] s, input logic fs, input logic [9:0] a);
        sel         = s;
        frame_start = fs;
        vga_valid   = 1'b1;
        vga_addr    = a;
        tick();
        frame_start = 1'b0;
        vga_valid   = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rgb_mem[i]  = 12'h111;
            gray_mem[i] = 12'h222;
            gx_mem[i]   = 12'h331;
            gy_mem[i]   = 12'h441;
        end
        rgb_mem[10'h030] = 12'hA5C;
        gx_mem[10'h030]  = 12'h000;
        gy_mem[10'h030]  = 12'h000;
        gx_mem[10'h040]  = 12'h7A9;
        gy_mem[10'h040]  = 12'h3B9;
        gx_mem[10'h041]  = 12'h003;
        gy_mem[10'h041]  = 12'h002;
        gx_mem[10'h050]  = 12'h004;
        gy_mem[10'h050]  = 12'h003;
        gx_mem[10'h051]  = 12'h005;
        gy_mem[10'h051]  = 12'h003;
        gray_mem[10'h060] = 12'h3C7;
        gx_mem[10'h060]   = 12'h00E;
        gy_mem[10'h060]   = 12'h00D;

        rst = 1'b1; sel = 3'd7; proc_done = 1'b1; proc_addr = 10'h3FF;
        vga_addr = 10'h2AB; vga_valid = 1'b1; frame_start = 1'b1;
        tick(); tick(); tick();
        checkOutput("reset.rd_addr", {22'd0, rd_addr}, 32'h0);
        checkPixel("reset", 12'h000, 1'b0);
        checkOutput("reset.active_sel", {29'd0, active_sel}, 32'd0);
        checkOutput("reset.disp_active", {31'd0, disp_active}, 32'd0);

        rst = 1'b0; proc_done = 1'b0; proc_addr = 10'h155;
        vga_valid = 1'b0; frame_start = 1'b0; sel = 3'd0; vga_addr = 10'h030;
        tick();
        checkOutput("proc.rd_addr", {22'd0, rd_addr}, 32'h155);
        checkOutput("proc.valid", {31'd0, pix_valid}, 32'd0);

        proc_done = 1'b1;
        tick();
        checkOutput("wait.entry_rd_addr", {22'd0, rd_addr}, 32'h155);
        tick();
        checkOutput("wait.rd_addr", {22'd0, rd_addr}, 32'h030);
        checkOutput("wait.disp_active", {31'd0, disp_active}, 32'd0);
        checkOutput("wait.valid", {31'd0, pix_valid}, 32'd0);

        sel = 3'd0; frame_start = 1'b1; vga_valid = 1'b1; vga_addr = 10'h030;
        tick();
        checkOutput("first.rd_addr", {22'd0, rd_addr}, 32'h030);
        checkOutput("first.disp_active", {31'd0, disp_active}, 32'd1);
        checkOutput("first.active_sel", {29'd0, active_sel}, 32'd0);
        frame_start = 1'b0; vga_valid = 1'b0;
        tick();
        checkOutput("first.early_valid", {31'd0, pix_valid}, 32'd0);
        tick();
        checkPixel("first.rgb_mode", 12'hA5C, 1'b1);
        tick();
        checkOutput("first.after_valid", {31'd0, pix_valid}, 32'd0);

        applyStimulus(3'd4, 1'b1, 10'h040);
        checkPixel("mag.sat", 12'hFFF, 1'b1);
        checkOutput("mag.active_sel", {29'd0, active_sel}, 32'd4);
        applyStimulus(3'd4, 1'b0, 10'h041);
        checkPixel("mag.sum", 12'h555, 1'b1);
        applyStimulus(3'd5, 1'b1, 10'h050);
        checkPixel("edge.below", 12'h000, 1'b1);
        applyStimulus(3'd5, 1'b0, 10'h051);
        checkPixel("edge.at", 12'hFFF, 1'b1);
        applyStimulus(3'd6, 1'b1, 10'h030);
        checkPixel("reserved6", 12'h000, 1'b1);
        applyStimulus(3'd1, 1'b1, 10'h060);
        checkPixel("gray", 12'h3C7, 1'b1);
        applyStimulus(3'd2, 1'b0, 10'h060);
        checkPixel("midframe.gray", 12'h3C7, 1'b1);
        checkOutput("midframe.active_sel", {29'd0, active_sel}, 32'd1);
        applyStimulus(3'd2, 1'b1, 10'h060);
        checkPixel("gx", 12'hEEE, 1'b1);
        checkOutput("gx.active_sel", {29'd0, active_sel}, 32'd2);
        applyStimulus(3'd3, 1'b1, 10'h060);
        checkPixel("gy", 12'hDDD, 1'b1);

        sel = 3'd3; vga_valid = 1'b1; vga_addr = 10'h030; proc_addr = 10'h2AA;
        tick();
        proc_done = 1'b0;
        tick();
        checkOutput("drop.disp_active", {31'd0, disp_active}, 32'd0);
        checkOutput("drop.rd_addr", {22'd0, rd_addr}, 32'h030);
        tick();
        checkPixel("drop.flushed", 12'h000, 1'b0);
        checkOutput("drop.rd_addr_proc", {22'd0, rd_addr}, 32'h2AA);

        proc_done = 1'b1; vga_valid = 1'b0;
        tick();
        proc_done = 1'b0; frame_start = 1'b1; vga_valid = 1'b1; proc_addr = 10'h0F0; sel = 3'd1;
        tick();
        checkOutput("race.disp_active", {31'd0, disp_active}, 32'd0);
        checkOutput("race.active_sel", {29'd0, active_sel}, 32'd3);
        frame_start = 1'b0;
        tick();
        checkOutput("race.rd_addr", {22'd0, rd_addr}, 32'h0F0);
        checkOutput("race.valid", {31'd0, pix_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
